// File: rtl/dice_cgra_disp_pkg.sv
// Shared types and width derivations for the CGRA thread-issue dispatcher.
// Optional perf counters in the top are enabled by DICE_CGRA_DISP_PERF_EN.
package dice_cgra_disp_pkg;

  localparam int DEF_NUM_TID   = 512;
  localparam int DEF_MAX_DRAIN = 64;

  function automatic int tid_width(input int num_tid);
    return $clog2(num_tid + 1);
  endfunction

  function automatic int drain_width(input int max_drain);
    return $clog2(max_drain + 1);
  endfunction

  localparam int DEF_TID_W   = tid_width(DEF_NUM_TID);
  localparam int DEF_DRAIN_W = drain_width(DEF_MAX_DRAIN);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    DRAIN,
    DONE
  } disp_state_e;

endpackage

// File: rtl/dice_cgra_dispatcher_prio_enc.sv
// Lowest-set-bit priority encoder built as a binary tree over a power-of-two
// padded input; each node keeps the winning index of its subtree.
module dice_lsb_prio_enc #(
  parameter int WIDTH = 512,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  localparam int P = 1 << IDX_W;

  logic [P-1:0]     vec_pad;
  logic             leaf_f   [0:P-1];
  logic             node_f   [1:2*P-1];
  logic [IDX_W-1:0] node_idx [1:2*P-1];

  assign vec_pad = P'(vec);

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_leaf
      assign leaf_f[gi] = vec_pad[gi];
    end
  endgenerate

  // Heap layout: node n has children 2n and 2n+1; leaves sit at P..2P-1.
  always_comb begin
    for (int n = 0; n < P; n++) begin
      node_f[P+n]   = leaf_f[n];
      node_idx[P+n] = IDX_W'(n);
    end
    for (int n = P - 1; n >= 1; n--) begin
      node_f[n]   = node_f[2*n] | node_f[2*n+1];
      node_idx[n] = node_f[2*n] ? node_idx[2*n] : node_idx[2*n+1];
    end
  end

  assign found = node_f[1];
  assign idx   = node_idx[1];

endmodule

// File: rtl/dice_cgra_dispatcher.sv
// Thread-issue sequencer: streams active TIDs in ascending order, drains, then
// pulses done. Define DICE_CGRA_DISP_PERF_EN to add issue/stall perf counters.
module dice_cgra_dispatcher
  import dice_cgra_disp_pkg::*;
#(
  parameter int NUM_TID   = DEF_NUM_TID,
  parameter int MAX_DRAIN = DEF_MAX_DRAIN,
  parameter int TID_W     = tid_width(NUM_TID),
  parameter int DRAIN_W   = drain_width(MAX_DRAIN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_TID-1:0] tid_mask,
  input  logic [DRAIN_W-1:0] drain_latency,
  input  logic               stall,
  input  logic               abort,
  output logic [TID_W-1:0]   disp_tid,
  output logic               disp_valid,
  output logic               cgra_clr,
  output logic               busy,
  output logic               done
`ifdef DICE_CGRA_DISP_PERF_EN
  ,
  output logic [31:0]        perf_issued,
  output logic [31:0]        perf_stall
`endif
);

  localparam int IDX_W = (NUM_TID > 1) ? $clog2(NUM_TID) : 1;

  disp_state_e        state_reg, state_next;
  logic [NUM_TID-1:0] mask_reg, mask_next, mask_low_clr;
  logic [DRAIN_W-1:0] drain_q_reg, drain_q_next;
  logic [DRAIN_W-1:0] cnt_reg, cnt_next;
  logic [TID_W-1:0]   tid_reg, tid_next;
  logic               valid_reg, valid_next;
  logic               clr_reg, clr_next;
  logic               done_reg, done_next;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_found;

  dice_lsb_prio_enc #(
    .WIDTH (NUM_TID),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec   (mask_reg),
    .idx   (enc_idx),
    .found (enc_found)
  );

  // x & (x-1) drops exactly the lowest set bit, the one the encoder selected.
  assign mask_low_clr = mask_reg & (mask_reg - NUM_TID'(1));

  always_comb begin
    state_next   = state_reg;
    mask_next    = mask_reg;
    drain_q_next = drain_q_reg;
    cnt_next     = cnt_reg;
    tid_next     = tid_reg;
    valid_next   = 1'b0;
    clr_next     = 1'b0;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = CLEAR;
          mask_next    = tid_mask;
          drain_q_next = drain_latency;
          clr_next     = 1'b1;
        end
      end
      CLEAR: begin
        if (mask_reg != '0) begin
          state_next = ISSUE;
        end else begin
          state_next = DONE;
          done_next  = 1'b1;
        end
      end
      ISSUE: begin
        if (!stall && enc_found) begin
          valid_next = 1'b1;
          tid_next   = TID_W'(enc_idx);
          mask_next  = mask_low_clr;
          if (mask_low_clr == '0) begin
            state_next = DRAIN;
            cnt_next   = drain_q_reg;
          end
        end
      end
      DRAIN: begin
        // Leaving at count <= 1 puts DONE max(1, drain) cycles after the last issue.
        if (cnt_reg <= DRAIN_W'(1)) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - DRAIN_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (abort && (state_reg != IDLE)) begin
      state_next = IDLE;
      mask_next  = '0;
      tid_next   = tid_reg;
      valid_next = 1'b0;
      clr_next   = 1'b1;
      done_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      mask_reg    <= '0;
      drain_q_reg <= '0;
      cnt_reg     <= '0;
      tid_reg     <= '0;
      valid_reg   <= 1'b0;
      clr_reg     <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mask_reg    <= mask_next;
      drain_q_reg <= drain_q_next;
      cnt_reg     <= cnt_next;
      tid_reg     <= tid_next;
      valid_reg   <= valid_next;
      clr_reg     <= clr_next;
      done_reg    <= done_next;
    end
  end

  assign disp_tid   = tid_reg;
  assign disp_valid = valid_reg;
  assign cgra_clr   = clr_reg;
  assign done       = done_reg;
  assign busy       = (state_reg != IDLE);

`ifdef DICE_CGRA_DISP_PERF_EN
  logic [31:0] perf_issued_reg, perf_stall_reg;

  always_ff @(posedge clk) begin
    if (rst || (state_reg == IDLE && start)) begin
      perf_issued_reg <= '0;
      perf_stall_reg  <= '0;
    end else begin
      if (valid_reg && (perf_issued_reg != '1))
        perf_issued_reg <= perf_issued_reg + 32'd1;
      if ((state_reg == ISSUE) && stall && (perf_stall_reg != '1))
        perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_issued = perf_issued_reg;
  assign perf_stall  = perf_stall_reg;
`endif

endmodule
